// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - pipelined RV32/RV64 immediate decoder with 2-entry valid/ready output stage (optional CSR decode: IMMGEN_ZICSR_EN)
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [31:0]      imm32;
    logic             imm_sext;
    logic [2:0]       dec_fmt;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [2:0]       main_fmt;
    logic             main_ill;
    logic [TAG_W-1:0] main_tag;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_ill;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             main_free;

    // Classify the opcode and build a 32-bit immediate before extension to XLEN
    always_comb begin
        dec_fmt  = FMT_ILL;
        imm32    = 32'd0;
        imm_sext = 1'b1;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
            7'b0011011: if (XLEN == 64) dec_fmt = FMT_I;
            7'b0100011: dec_fmt = FMT_S;
            7'b1100011: dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111: dec_fmt = FMT_J;
            7'b0110011: dec_fmt = FMT_R;
            7'b0111011: if (XLEN == 64) dec_fmt = FMT_R;
`ifdef IMMGEN_ZICSR_EN
            7'b1110011: dec_fmt = FMT_CSR;
`endif
            default: dec_fmt = FMT_ILL;
        endcase
        case (dec_fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'd0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
`ifdef IMMGEN_ZICSR_EN
            FMT_CSR: begin
                // CSR address and zimm are unsigned fields, never sign-extended
                imm32    = {15'd0, in_instr[31:20], in_instr[19:15]};
                imm_sext = 1'b0;
            end
`endif
            default: imm32 = 32'd0;
        endcase
        dec_imm = imm_sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
        dec_ill = (dec_fmt == FMT_ILL);
    end

    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    // Main/skid pair: main feeds the outputs, skid absorbs one entry while main is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_fmt   <= 3'd0;
            main_ill   <= 1'b0;
            main_tag   <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_fmt   <= 3'd0;
            skid_ill   <= 1'b0;
            skid_tag   <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_fmt   <= skid_fmt;
                main_ill   <= skid_ill;
                main_tag   <= skid_tag;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_imm   <= dec_imm;
                main_fmt   <= dec_fmt;
                main_ill   <= dec_ill;
                main_tag   <= in_tag;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
            skid_tag   <= in_tag;
        end
    end

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign out_imm     = main_imm;
    assign out_fmt     = main_fmt;
    assign out_illegal = main_ill;
    assign out_tag     = main_tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage (XLEN 32 and 64 side by side)
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_tag;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;
    logic [31:0] out_tag64;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk32(input string tag, input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_imm"}, 64'(out_imm), 64'(imm));
        check({tag, "_fmt"}, 64'(out_fmt), 64'(fmt));
        check({tag, "_ill"}, 64'(out_illegal), 64'(ill));
    endtask

    int got[$];
    logic fire_out, fire_in;
    logic [31:0] seen_tag;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        step(); step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_fmt", 64'(out_fmt), 64'd0);
        check("rst_ill", 64'(out_illegal), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        send(32'hFFF00093, 32'd100);
        chk32("i_neg1", 32'hFFFFFFFF, 3'd1, 1'b0);
        check("i_neg1_tag", 64'(out_tag), 64'd100);
        check("i_neg1_64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        send(32'hFE112E23, 32'd101);
        chk32("s_sw", 32'hFFFFFFFC, 3'd2, 1'b0);
        send(32'hFE000CE3, 32'd102);
        chk32("b_beq", 32'hFFFFFFF8, 3'd3, 1'b0);
        send(32'h123452B7, 32'd103);
        chk32("u_lui", 32'h12345000, 3'd4, 1'b0);
        send(32'h001000EF, 32'd104);
        chk32("j_jal", 32'h00000800, 3'd5, 1'b0);
        send(32'h800002B7, 32'd105);
        check("u_lui64", out_imm64, 64'hFFFFFFFF80000000);
        check("u_lui32", 64'(out_imm), 64'h80000000);
        send(32'h0010009B, 32'd106);
        chk32("addiw32", 32'h0, 3'd7, 1'b1);
        check("addiw64_fmt", 64'(out_fmt64), 64'd1);
        check("addiw64_imm", out_imm64, 64'd1);
        check("addiw64_ill", 64'(out_illegal64), 64'd0);
        send(32'h002081B3, 32'd107);
        chk32("r_add", 32'h0, 3'd0, 1'b0);
        send(32'h0000007F, 32'd108);
        chk32("ill_op", 32'h0, 3'd7, 1'b1);
        send(32'h30029073, 32'd109);
`ifdef IMMGEN_ZICSR_EN
        chk32("csr", 32'h00006005, 3'd6, 1'b0);
        check("csr64_imm", out_imm64, 64'h6005);
`else
        chk32("csr", 32'h0, 3'd7, 1'b1);
        check("csr64_imm", out_imm64, 64'h0);
`endif
        step();
        check("drain_empty", 64'(out_valid), 64'd0);

        // Backpressure: four tags, consumer stalled for three cycles
        out_ready = 1'b0;
        send(32'h00100093, 32'd1);
        check("bp_main_tag", 64'(out_tag), 64'd1);
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        send(32'h00200093, 32'd2);
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_instr = 32'h00300093; in_tag = 32'd3;
        step();
        check("bp_hold_tag", 64'(out_tag), 64'd1);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_imm", 64'(out_imm), 64'd1);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            fire_out = out_valid && out_ready;
            seen_tag = out_tag;
            fire_in  = in_valid && in_ready;
            step();
            if (fire_out) got.push_back(int'(seen_tag));
            if (fire_in) begin
                if (in_tag == 32'd4) in_valid = 1'b0;
                else begin
                    in_tag   = in_tag + 32'd1;
                    in_instr = {in_tag[11:0] + 12'd0, 20'h00093};
                end
            end
            if (cyc == 3) check("bp_count_4cyc", 64'(got.size()), 64'd4);
        end
        check("bp_count_total", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("bp_order", 64'((i < got.size()) ? got[i] : -1), 64'(i + 1));

        // Flush with main and skid full and an input offered
        out_ready = 1'b0;
        send(32'h00A00093, 32'd10);
        send(32'h00B00093, 32'd11);
        check("fl_skid_full", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_instr = 32'h00C00093; in_tag = 32'd12; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(32'h00D00093, 32'd13);
        check("fl_next_tag", 64'(out_tag), 64'd13);
        step();
        check("fl_no_stale", 64'(out_valid), 64'd0);
        // Flush drops an input even while in_ready is high
        in_valid = 1'b1; in_tag = 32'd14; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_drop_in", 64'(out_valid), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h00100093, 32'd20);
        send(32'h00200093, 32'd21);
        rst_n = 1'b0;
        step(); step();
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_imm", 64'(out_imm), 64'd0);
        check("mrst_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        send(32'hFFF00093, 32'd22);
        chk32("mrst_first", 32'hFFFFFFFF, 3'd1, 1'b0);
        check("mrst_first_tag", 64'(out_tag), 64'd22);
        out_ready = 1'b1;
        step();
        check("mrst_no_old", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
